// File: rtl/spu_result_pipe.sv
// Seven-stage result staging shift register for one SPU pipe; each op's stage-7 copy is registered onto the RF write port, so writeback lands 8 cycles after issue.
// No backpressure: the pipe shifts every cycle, and a flush kills the incoming op plus stages 2..FLUSH_STAGES.
module spu_result_pipe #(
    parameter int DATA_W       = 128,
    parameter int FLUSH_STAGES = 2,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [0:6]        in_reg_dst,
    input  logic              in_reg_wr,
    input  logic [0:3]        in_latency,
    input  logic [0:DATA_W-1] in_result,
    input  logic              flush,
    output logic [0:6]        reg_dst_1stage_o,
    output logic [0:6]        reg_dst_2stage_o,
    output logic [0:6]        reg_dst_3stage_o,
    output logic [0:6]        reg_dst_4stage_o,
    output logic [0:6]        reg_dst_5stage_o,
    output logic [0:6]        reg_dst_6stage_o,
    output logic [0:6]        reg_dst_7stage_o,
    output logic              reg_wr_1stage_o,
    output logic              reg_wr_2stage_o,
    output logic              reg_wr_3stage_o,
    output logic              reg_wr_4stage_o,
    output logic              reg_wr_5stage_o,
    output logic              reg_wr_6stage_o,
    output logic              reg_wr_7stage_o,
    output logic [0:3]        latency_1stage_o,
    output logic [0:3]        latency_2stage_o,
    output logic [0:3]        latency_3stage_o,
    output logic [0:3]        latency_4stage_o,
    output logic [0:3]        latency_5stage_o,
    output logic [0:3]        latency_6stage_o,
    output logic [0:3]        latency_7stage_o,
    output logic [0:DATA_W-1] result_1stage_o,
    output logic [0:DATA_W-1] result_2stage_o,
    output logic [0:DATA_W-1] result_3stage_o,
    output logic [0:DATA_W-1] result_4stage_o,
    output logic [0:DATA_W-1] result_5stage_o,
    output logic [0:DATA_W-1] result_6stage_o,
    output logic [0:DATA_W-1] result_7stage_o,
    output logic              ready_1stage_o,
    output logic              ready_2stage_o,
    output logic              ready_3stage_o,
    output logic              ready_4stage_o,
    output logic              ready_5stage_o,
    output logic              ready_6stage_o,
    output logic              ready_7stage_o,
    output logic              wb_en,
    output logic [0:6]        wb_addr,
    output logic [0:DATA_W-1] wb_data,
    output logic [0:CNT_W-1]  retired_cnt
);

    logic              vld_q [1:7];
    logic              vld_d [1:7];
    logic              wr_q  [1:7];
    logic              wr_d  [1:7];
    logic [0:6]        dst_q [1:7];
    logic [0:6]        dst_d [1:7];
    logic [0:3]        lat_q [1:7];
    logic [0:3]        lat_d [1:7];
    logic [0:DATA_W-1] res_q [1:7];
    logic [0:DATA_W-1] res_d [1:7];

    logic              wb_en_q,   wb_en_d;
    logic [0:6]        wb_addr_q, wb_addr_d;
    logic [0:DATA_W-1] wb_data_q, wb_data_d;
    logic [0:CNT_W-1]  cnt_q,     cnt_d;

    logic [0:3]        lat_clamp;
    logic              stage_wr  [1:7];
    logic              stage_rdy [1:7];

    // Latency is clamped once at entry so every later stage compares against 1..7.
    always_comb begin
        lat_clamp = in_latency;
        if (in_latency == 4'd0) begin
            lat_clamp = 4'd1;
        end else if (in_latency > 4'd7) begin
            lat_clamp = 4'd7;
        end
    end

    always_comb begin
        for (int k = 2; k <= 7; k++) begin
            vld_d[k] = vld_q[k-1];
            wr_d[k]  = wr_q[k-1];
            dst_d[k] = dst_q[k-1];
            lat_d[k] = lat_q[k-1];
            res_d[k] = res_q[k-1];
            if (flush && (k <= FLUSH_STAGES)) begin
                vld_d[k] = 1'b0;
                wr_d[k]  = 1'b0;
                dst_d[k] = '0;
                lat_d[k] = '0;
                res_d[k] = '0;
            end
        end
        vld_d[1] = 1'b0;
        wr_d[1]  = 1'b0;
        dst_d[1] = '0;
        lat_d[1] = '0;
        res_d[1] = '0;
        // A redirect in the same cycle drops the incoming op.
        if (in_valid && !flush) begin
            vld_d[1] = 1'b1;
            wr_d[1]  = in_reg_wr;
            dst_d[1] = in_reg_dst;
            lat_d[1] = lat_clamp;
            res_d[1] = in_result;
        end
    end

    always_comb begin
        wb_en_d   = vld_q[7] && wr_q[7];
        wb_addr_d = dst_q[7];
        wb_data_d = res_q[7];
        cnt_d     = cnt_q;
        if (wb_en_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        for (int n = 1; n <= 7; n++) begin
            stage_wr[n]  = vld_q[n] && wr_q[n];
            stage_rdy[n] = stage_wr[n] && (lat_q[n] <= 4'(n));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= 7; k++) begin
                vld_q[k] <= 1'b0;
                wr_q[k]  <= 1'b0;
                dst_q[k] <= '0;
                lat_q[k] <= '0;
                res_q[k] <= '0;
            end
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            vld_q     <= vld_d;
            wr_q      <= wr_d;
            dst_q     <= dst_d;
            lat_q     <= lat_d;
            res_q     <= res_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign reg_dst_1stage_o = dst_q[1];
    assign reg_dst_2stage_o = dst_q[2];
    assign reg_dst_3stage_o = dst_q[3];
    assign reg_dst_4stage_o = dst_q[4];
    assign reg_dst_5stage_o = dst_q[5];
    assign reg_dst_6stage_o = dst_q[6];
    assign reg_dst_7stage_o = dst_q[7];

    assign reg_wr_1stage_o = stage_wr[1];
    assign reg_wr_2stage_o = stage_wr[2];
    assign reg_wr_3stage_o = stage_wr[3];
    assign reg_wr_4stage_o = stage_wr[4];
    assign reg_wr_5stage_o = stage_wr[5];
    assign reg_wr_6stage_o = stage_wr[6];
    assign reg_wr_7stage_o = stage_wr[7];

    assign latency_1stage_o = lat_q[1];
    assign latency_2stage_o = lat_q[2];
    assign latency_3stage_o = lat_q[3];
    assign latency_4stage_o = lat_q[4];
    assign latency_5stage_o = lat_q[5];
    assign latency_6stage_o = lat_q[6];
    assign latency_7stage_o = lat_q[7];

    assign result_1stage_o = res_q[1];
    assign result_2stage_o = res_q[2];
    assign result_3stage_o = res_q[3];
    assign result_4stage_o = res_q[4];
    assign result_5stage_o = res_q[5];
    assign result_6stage_o = res_q[6];
    assign result_7stage_o = res_q[7];

    assign ready_1stage_o = stage_rdy[1];
    assign ready_2stage_o = stage_rdy[2];
    assign ready_3stage_o = stage_rdy[3];
    assign ready_4stage_o = stage_rdy[4];
    assign ready_5stage_o = stage_rdy[5];
    assign ready_6stage_o = stage_rdy[6];
    assign ready_7stage_o = stage_rdy[7];

    assign wb_en       = wb_en_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_spu_result_pipe.sv
// Bench for spu_result_pipe: vector table for stage-1 behaviour, hand sequences for
// stage tracking, flush, mid-pipe reset and counter saturation; writebacks go through a scoreboard.
module tb_spu_result_pipe;

    localparam int DW = 128;
    localparam int NV = 17;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic [6:0]      in_reg_dst;
    logic            in_reg_wr;
    logic [3:0]      in_latency;
    logic [DW-1:0]   in_result;
    logic            flush;

    logic [6:0]      dst_o [1:7];
    logic            wr_o  [1:7];
    logic [3:0]      lat_o [1:7];
    logic [DW-1:0]   res_o [1:7];
    logic            rdy_o [1:7];
    logic            wb_en;
    logic [6:0]      wb_addr;
    logic [DW-1:0]   wb_data;
    logic [3:0]      retired_cnt;

    spu_result_pipe #(.DATA_W(DW), .FLUSH_STAGES(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_reg_dst(in_reg_dst),
        .in_reg_wr(in_reg_wr), .in_latency(in_latency), .in_result(in_result), .flush(flush),
        .reg_dst_1stage_o(dst_o[1]), .reg_dst_2stage_o(dst_o[2]), .reg_dst_3stage_o(dst_o[3]),
        .reg_dst_4stage_o(dst_o[4]), .reg_dst_5stage_o(dst_o[5]), .reg_dst_6stage_o(dst_o[6]),
        .reg_dst_7stage_o(dst_o[7]),
        .reg_wr_1stage_o(wr_o[1]), .reg_wr_2stage_o(wr_o[2]), .reg_wr_3stage_o(wr_o[3]),
        .reg_wr_4stage_o(wr_o[4]), .reg_wr_5stage_o(wr_o[5]), .reg_wr_6stage_o(wr_o[6]),
        .reg_wr_7stage_o(wr_o[7]),
        .latency_1stage_o(lat_o[1]), .latency_2stage_o(lat_o[2]), .latency_3stage_o(lat_o[3]),
        .latency_4stage_o(lat_o[4]), .latency_5stage_o(lat_o[5]), .latency_6stage_o(lat_o[6]),
        .latency_7stage_o(lat_o[7]),
        .result_1stage_o(res_o[1]), .result_2stage_o(res_o[2]), .result_3stage_o(res_o[3]),
        .result_4stage_o(res_o[4]), .result_5stage_o(res_o[5]), .result_6stage_o(res_o[6]),
        .result_7stage_o(res_o[7]),
        .ready_1stage_o(rdy_o[1]), .ready_2stage_o(rdy_o[2]), .ready_3stage_o(rdy_o[3]),
        .ready_4stage_o(rdy_o[4]), .ready_5stage_o(rdy_o[5]), .ready_6stage_o(rdy_o[6]),
        .ready_7stage_o(rdy_o[7]),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .retired_cnt(retired_cnt)
    );

    typedef struct {
        logic       vld;
        logic       wr;
        logic [6:0] dst;
        logic [3:0] lat;
        logic       flush;
        logic       exp_wr1;
        logic [3:0] exp_lat1;
        logic       exp_rdy1;
        logic       chk_lat;
        logic       exp_wb;
    } vec_t;

    typedef struct {
        int            due;
        logic [6:0]    dst;
        logic [DW-1:0] res;
    } sb_t;

    vec_t tbl [0:NV-1];
    sb_t  sb [$];
    sb_t  mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   model_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mkres(input logic [6:0] d);
        return {16{1'b1, d}};
    endfunction

    // Writeback monitor: every wb_en must match the oldest expected op on its due cycle.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            model_cnt = 0;
        end else begin
            if (wb_en) begin
                if (sb.size() == 0) begin
                    chk("wb_spurious", {127'd0, wb_en}, '0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("wb_cycle", DW'(cyc), DW'(mon_e.due));
                    chk("wb_addr", {121'd0, wb_addr}, {121'd0, mon_e.dst});
                    chk("wb_data", wb_data, mon_e.res);
                    if (model_cnt != 15) model_cnt++;
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                chk("wb_missing", {127'd0, wb_en}, 128'd1);
                void'(sb.pop_front());
            end
            chk("retired_cnt", {124'd0, retired_cnt}, DW'(model_cnt));
        end
    end

    task automatic drive(input logic v, input logic w, input logic [6:0] d,
                         input logic [3:0] l, input logic f, input logic push);
        in_valid   = v;
        in_reg_wr  = w;
        in_reg_dst = d;
        in_latency = l;
        in_result  = mkres(d);
        flush      = f;
        if (push) sb.push_back('{due: cyc + 8, dst: d, res: mkres(d)});
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b0);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(tbl[i].vld, tbl[i].wr, tbl[i].dst, tbl[i].lat, tbl[i].flush, tbl[i].exp_wb);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wr1", i), {127'd0, wr_o[1]}, {127'd0, tbl[i].exp_wr1});
            chk($sformatf("v%0d_rdy1", i), {127'd0, rdy_o[1]}, {127'd0, tbl[i].exp_rdy1});
            if (tbl[i].chk_lat)
                chk($sformatf("v%0d_lat1", i), {124'd0, lat_o[1]}, {124'd0, tbl[i].exp_lat1});
        end
        drive(1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b0);
    endtask

    // Issue one op and walk it through all seven stages.
    task automatic follow_op(input logic [6:0] d, input logic [3:0] l, input int first_rdy);
        drive(1'b1, 1'b1, d, l, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b0);
        for (int n = 1; n <= 7; n++) begin
            chk($sformatf("fol%0d_wr%0d", d, n), {127'd0, wr_o[n]}, 128'd1);
            chk($sformatf("fol%0d_rdy%0d", d, n), {127'd0, rdy_o[n]}, {127'd0, (n >= first_rdy)});
            chk($sformatf("fol%0d_dst%0d", d, n), {121'd0, dst_o[n]}, {121'd0, d});
            if (n < 7) begin
                @(posedge clk);
                #1;
            end
        end
        chk($sformatf("fol%0d_res7", d), res_o[7], mkres(d));
    endtask

    initial begin
        for (int k = 0; k < 8; k++)
            tbl[k] = '{1'b1, 1'b1, 7'(k), 4'd2, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 7'd20, 4'd0,  1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 7'd21, 4'd9,  1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 7'd22, 4'd15, 1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 7'd23, 4'd1,  1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 7'd24, 4'd5,  1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 7'd30, 4'd1,  1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b1};
        tbl[14] = '{1'b1, 1'b1, 7'd31, 4'd1,  1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b1};
        tbl[15] = '{1'b1, 1'b1, 7'd32, 4'd1,  1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 7'd33, 4'd1,  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};

        in_valid = 1'b0; in_reg_wr = 1'b0; in_reg_dst = '0; in_latency = '0;
        in_result = '0; flush = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst_wb_en", {127'd0, wb_en}, '0);
        chk("rst_cnt", {124'd0, retired_cnt}, '0);
        chk("rst_wr1", {127'd0, wr_o[1]}, '0);
        chk("rst_lat7", {124'd0, lat_o[7]}, '0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single op, latency 3: ready from stage 3 onward, writeback 8 cycles after issue.
        follow_op(7'd5, 4'd3, 3);
        idle(3);

        // Eight ops back to back: stage N holds dst 8-N once the eighth is in stage 1.
        run_vectors(0, 7);
        for (int n = 1; n <= 7; n++)
            chk($sformatf("b2b_dst%0d", n), {121'd0, dst_o[n]}, DW'(8 - n));
        idle(10);

        run_vectors(8, 12);
        follow_op(7'd40, 4'd9, 7);
        idle(10);

        // Flush arrives with D: C (stage 1) and D die, B and A keep going.
        run_vectors(13, 16);
        chk("fl_wr2", {127'd0, wr_o[2]}, '0);
        chk("fl_wr3", {127'd0, wr_o[3]}, 128'd1);
        chk("fl_dst3", {121'd0, dst_o[3]}, 128'd31);
        chk("fl_dst4", {121'd0, dst_o[4]}, 128'd30);
        idle(12);

        // Write-disabled op, then reset with three ops in flight.
        drive(1'b1, 1'b0, 7'd50, 4'd2, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 7'(60 + k), 4'd1, 1'b0, 1'b1);
            @(posedge clk);
            #1;
        end
        idle(2);
        #1 rst = 1'b0;
        #1;
        chk("mrst_wb_en", {127'd0, wb_en}, '0);
        chk("mrst_cnt", {124'd0, retired_cnt}, '0);
        for (int n = 1; n <= 7; n++) begin
            chk($sformatf("mrst_wr%0d", n), {127'd0, wr_o[n]}, '0);
            chk($sformatf("mrst_dst%0d", n), {121'd0, dst_o[n]}, '0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle(12);

        // Twenty retirements into a 4-bit counter must stop at 15.
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 1'b1, 7'(70 + k), 4'd2, 1'b0, 1'b1);
            @(posedge clk);
            #1;
        end
        idle(12);
        chk("sat_cnt", {124'd0, retired_cnt}, 128'd15);
        chk("sb_drain", DW'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
